// File: rtl/ahb_arbiter_rr_if.sv
// Arbiter-side AHB signal bundle: requests and muxed bus status in, grant and ownership out.
// Shared between the round-robin arbiter and whatever drives the master-side requests.
interface ahb_arbiter_rr_if #(
    parameter int unsigned P_NUMM = 5
);
    logic [P_NUMM-1:0] hbusreq;
    logic [P_NUMM-1:0] hlock;
    logic [P_NUMM-1:0] hgrant;
    logic [3:0]        hmaster;
    logic              hmastlock;
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic              hready;
    logic [1:0]        hresp;
    logic [15:0]       hsplit;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB arbiter: honours fixed bursts, HLOCK and SPLIT masking,
// and caps undefined-length INCR tenure at P_MAX_TENURE address beats.
module ahb_arbiter_rr #(
    parameter int unsigned P_NUMM        = 5,
    parameter int unsigned P_DEFAULT_MST = 0,
    parameter int unsigned P_MAX_TENURE  = 16
) (
    input logic             i_hclk,
    input logic             i_hresetn,
    ahb_arbiter_rr_if.slave bus
);
    localparam logic [1:0] L_IDLE   = 2'b00;
    localparam logic [1:0] L_BUSY   = 2'b01;
    localparam logic [1:0] L_NONSEQ = 2'b10;
    localparam logic [1:0] L_SEQ    = 2'b11;
    localparam logic [1:0] L_OKAY   = 2'b00;
    localparam logic [1:0] L_SPLIT  = 2'b11;

    localparam logic [P_NUMM-1:0] L_ONE       = {{(P_NUMM-1){1'b0}}, 1'b1};
    localparam logic [P_NUMM-1:0] L_DEF_GRANT = L_ONE << P_DEFAULT_MST;
    localparam logic [3:0]        L_DEF_IDX   = 4'(P_DEFAULT_MST);
    localparam logic [7:0]        L_TENURE    = 8'(P_MAX_TENURE - 1);

    logic [P_NUMM-1:0] r_hgrant;
    logic [3:0]        r_hmaster;
    logic              r_hmastlock;
    logic [3:0]        r_hmaster_d;
    logic [P_NUMM-1:0] r_split_mask;
    logic              r_split_pend;
    logic [3:0]        r_rr_ptr;
    logic [7:0]        r_beat_cnt;

    logic [3:0]        w_grant_idx;
    logic [P_NUMM-1:0] w_eligible;
    logic [3:0]        w_winner;
    logic [3:0]        w_cand;
    logic              w_found;
    logic              w_grantee_lock;
    logic              w_lock_hold;
    logic              w_arb_cond;
    logic              w_arb_ok;
    logic              w_split_first;
    logic [P_NUMM-1:0] w_split_set;
    logic [P_NUMM-1:0] w_split_mask_nxt;

    always_comb begin
        w_grant_idx = '0;
        for (int unsigned i = 0; i < P_NUMM; i++) begin
            if (r_hgrant[i]) w_grant_idx = 4'(i);
        end
    end

    assign w_eligible     = bus.hbusreq & ~r_split_mask;
    assign w_grantee_lock = |(bus.hlock & (L_ONE << w_grant_idx));

    // Search starts just past the last winner; the last candidate is rr_ptr itself.
    always_comb begin
        w_found  = 1'b0;
        w_winner = L_DEF_IDX;
        w_cand   = '0;
        for (int unsigned k = 1; k <= P_NUMM; k++) begin
            w_cand = 4'((32'(r_rr_ptr) + k) % P_NUMM);
            if (!w_found && |(w_eligible & (L_ONE << w_cand))) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // A pending SPLIT overrides both the lock hold and the burst position.
    assign w_lock_hold = r_hmastlock && |(bus.hlock & (L_ONE << r_hmaster)) && !r_split_pend;

    always_comb begin
        w_arb_cond = 1'b0;
        unique case (bus.htrans)
            L_IDLE:   w_arb_cond = 1'b1;
            L_NONSEQ: w_arb_cond = (bus.hburst == 3'b000);
            L_SEQ:    w_arb_cond = (r_beat_cnt == 8'd1) || (r_beat_cnt == 8'd0);
            L_BUSY:   w_arb_cond = (r_beat_cnt == 8'd0);
        endcase
    end

    assign w_arb_ok = bus.hready && !w_lock_hold && (r_split_pend || w_arb_cond);

    assign w_split_first    = (bus.hresp == L_SPLIT) && !bus.hready && !r_split_pend;
    assign w_split_set      = w_split_first ? (L_ONE << r_hmaster_d) : '0;
    assign w_split_mask_nxt = (r_split_mask & ~bus.hsplit[P_NUMM-1:0]) | w_split_set;

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_hgrant     <= L_DEF_GRANT;
            r_hmaster    <= L_DEF_IDX;
            r_hmastlock  <= 1'b0;
            r_hmaster_d  <= L_DEF_IDX;
            r_split_mask <= '0;
            r_split_pend <= 1'b0;
            r_rr_ptr     <= L_DEF_IDX;
            r_beat_cnt   <= '0;
        end else begin
            r_split_mask <= w_split_mask_nxt;

            if (w_split_first) begin
                r_split_pend <= 1'b1;
            end else if (bus.hready) begin
                r_split_pend <= 1'b0;
            end

            if (bus.hresp != L_OKAY) begin
                r_beat_cnt <= '0;
            end else if (bus.hready) begin
                if (bus.htrans == L_NONSEQ) begin
                    unique case (bus.hburst)
                        3'b000:         r_beat_cnt <= 8'd0;
                        3'b001:         r_beat_cnt <= L_TENURE;
                        3'b010, 3'b011: r_beat_cnt <= 8'd3;
                        3'b100, 3'b101: r_beat_cnt <= 8'd7;
                        3'b110, 3'b111: r_beat_cnt <= 8'd15;
                    endcase
                end else if (bus.htrans == L_SEQ && r_beat_cnt != 8'd0) begin
                    r_beat_cnt <= r_beat_cnt - 8'd1;
                end
            end

            if (bus.hready) begin
                r_hmaster   <= w_grant_idx;
                r_hmastlock <= w_grantee_lock;
                r_hmaster_d <= r_hmaster;
            end

            if (w_arb_ok) begin
                r_hgrant <= L_ONE << w_winner;
                if (w_winner != w_grant_idx && |w_eligible) r_rr_ptr <= w_winner;
            end
        end
    end

    assign bus.hgrant    = r_hgrant;
    assign bus.hmaster   = r_hmaster;
    assign bus.hmastlock = r_hmastlock;
endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed vector bench for ahb_arbiter_rr: a table of per-cycle inputs and expected
// grant/owner/lock values, plus a hand-written asynchronous reset sequence mid-burst.
module tb_ahb_arbiter_rr;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b01, SPL = 2'b11;
    localparam logic [2:0] SGL = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

    typedef struct {
        logic [4:0]  br;
        logic [4:0]  hl;
        logic [1:0]  tr;
        logic [2:0]  bu;
        logic        rd;
        logic [1:0]  rs;
        logic [15:0] sp;
        logic [4:0]  eg;
        logic [3:0]  em;
        logic        el;
    } vec_t;

    logic clk = 1'b0;
    logic hresetn;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    ahb_arbiter_rr_if #(.P_NUMM(5)) bus ();

    ahb_arbiter_rr #(
        .P_NUMM       (5),
        .P_DEFAULT_MST(0),
        .P_MAX_TENURE (16)
    ) dut (
        .i_hclk   (clk),
        .i_hresetn(hresetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] br, input logic [4:0] hl, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rd, input logic [1:0] rs,
                       input logic [15:0] sp, input logic [4:0] eg, input logic [3:0] em,
                       input logic el);
        vec_t v;
        v.br = br; v.hl = hl; v.tr = tr; v.bu = bu; v.rd = rd; v.rs = rs; v.sp = sp;
        v.eg = eg; v.em = em; v.el = el;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] br, input logic [4:0] hl, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rd, input logic [1:0] rs,
                         input logic [15:0] sp);
        bus.hbusreq = br; bus.hlock = hl; bus.htrans = tr; bus.hburst = bu;
        bus.hready  = rd; bus.hresp = rs; bus.hsplit = sp;
    endtask

    task automatic check_outs(input string tag, input logic [4:0] eg, input logic [3:0] em,
                              input logic el);
        check({tag, " grant"}, 32'(bus.hgrant), 32'(eg));
        check({tag, " master"}, 32'(bus.hmaster), 32'(em));
        check({tag, " mastlock"}, 32'(bus.hmastlock), 32'(el));
    endtask

    initial begin
        // Idle bus parks on the default master.
        for (int i = 0; i < 3; i++) add(5'b00000, 0, IDLE, SGL, 1, OK, 0, 5'b00001, 0, 0);
        // Two SINGLE requesters alternate; owner lags the grant by one edge.
        add(5'b01010, 0, NSQ, SGL, 1, OK, 0, 5'b00010, 0, 0);
        add(5'b01010, 0, NSQ, SGL, 1, OK, 0, 5'b01000, 1, 0);
        add(5'b01010, 0, NSQ, SGL, 1, OK, 0, 5'b00010, 3, 0);
        add(5'b01010, 0, NSQ, SGL, 1, OK, 0, 5'b01000, 1, 0);
        // M2 INCR8 with M4 waiting, one wait state mid-burst.
        add(5'b00100, 0, IDLE, SGL, 1, OK, 0, 5'b00100, 3, 0);
        add(5'b00100, 0, IDLE, SGL, 1, OK, 0, 5'b00100, 2, 0);
        add(5'b10100, 0, NSQ, INCR8, 1, OK, 0, 5'b00100, 2, 0);
        for (int i = 0; i < 3; i++) add(5'b10100, 0, SEQ, INCR8, 1, OK, 0, 5'b00100, 2, 0);
        add(5'b10100, 0, SEQ, INCR8, 0, OK, 0, 5'b00100, 2, 0);
        for (int i = 0; i < 3; i++) add(5'b10100, 0, SEQ, INCR8, 1, OK, 0, 5'b00100, 2, 0);
        add(5'b10100, 0, SEQ, INCR8, 1, OK, 0, 5'b10000, 2, 0);
        add(5'b10000, 0, IDLE, SGL, 1, OK, 0, 5'b10000, 4, 0);
        // Locked M0 SINGLEs hold off M1 until HLOCK[0] drops.
        add(5'b00001, 5'b00001, IDLE, SGL, 1, OK, 0, 5'b00001, 4, 0);
        add(5'b00001, 5'b00001, IDLE, SGL, 1, OK, 0, 5'b00001, 0, 1);
        add(5'b00011, 5'b00001, NSQ, SGL, 1, OK, 0, 5'b00001, 0, 1);
        add(5'b00011, 5'b00001, NSQ, SGL, 1, OK, 0, 5'b00001, 0, 1);
        add(5'b00011, 5'b00000, IDLE, SGL, 1, OK, 0, 5'b00010, 0, 0);
        add(5'b00010, 5'b00000, IDLE, SGL, 1, OK, 0, 5'b00010, 1, 0);
        // SPLIT to M3 masks it; HSPLIT[3] (upper bits ignored) lets it back in.
        add(5'b01000, 0, IDLE, SGL, 1, OK, 0, 5'b01000, 1, 0);
        add(5'b01000, 0, IDLE, SGL, 1, OK, 0, 5'b01000, 3, 0);
        add(5'b01010, 0, NSQ, INCR4, 1, OK, 0, 5'b01000, 3, 0);
        add(5'b01010, 0, SEQ, INCR4, 0, SPL, 0, 5'b01000, 3, 0);
        add(5'b01010, 0, IDLE, SGL, 1, SPL, 0, 5'b00010, 3, 0);
        add(5'b01010, 0, IDLE, SGL, 1, OK, 0, 5'b00010, 1, 0);
        add(5'b01010, 0, NSQ, INCR4, 1, OK, 16'hFFE8, 5'b00010, 1, 0);
        add(5'b01010, 0, IDLE, SGL, 1, OK, 0, 5'b01000, 1, 0);
        // M2 INCR tenure cap of 16 beats with M0 waiting.
        add(5'b00100, 0, IDLE, SGL, 1, OK, 0, 5'b00100, 3, 0);
        add(5'b00100, 0, IDLE, SGL, 1, OK, 0, 5'b00100, 2, 0);
        add(5'b00101, 0, NSQ, INCR, 1, OK, 0, 5'b00100, 2, 0);
        for (int i = 0; i < 14; i++) add(5'b00101, 0, SEQ, INCR, 1, OK, 0, 5'b00100, 2, 0);
        add(5'b00101, 0, SEQ, INCR, 1, OK, 0, 5'b00001, 2, 0);
        add(5'b00101, 0, IDLE, SGL, 1, OK, 0, 5'b00100, 0, 0);
        add(5'b00101, 0, NSQ, INCR4, 1, OK, 0, 5'b00100, 2, 0);
        // ERROR clears the burst; grant moves only at the following IDLE.
        add(5'b00101, 0, SEQ, INCR4, 0, ERR, 0, 5'b00100, 2, 0);
        add(5'b00101, 0, IDLE, SGL, 1, ERR, 0, 5'b00001, 2, 0);
        // Locked M2 burst in flight, to be cut by reset below.
        add(5'b00100, 5'b00100, IDLE, SGL, 1, OK, 0, 5'b00100, 0, 0);
        add(5'b00100, 5'b00100, NSQ, INCR4, 1, OK, 0, 5'b00100, 2, 1);

        drive(0, 0, IDLE, SGL, 1, OK, 0);
        hresetn = 1'b1;
        #1 hresetn = 1'b0;
        #1 check_outs("reset", 5'b00001, 0, 0);
        @(negedge clk);
        hresetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].br, vecs[i].hl, vecs[i].tr, vecs[i].bu, vecs[i].rd, vecs[i].rs,
                  vecs[i].sp);
            @(posedge clk);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].eg, vecs[i].em, vecs[i].el);
        end

        // Asynchronous reset between edges while M2 is mid-burst.
        @(negedge clk);
        drive(5'b00100, 5'b00100, SEQ, INCR4, 1, OK, 0);
        #2 hresetn = 1'b0;
        #1 check_outs("async_rst", 5'b00001, 0, 0);
        @(posedge clk);
        #1 check_outs("rst_held", 5'b00001, 0, 0);
        @(negedge clk);
        hresetn = 1'b1;
        drive(0, 0, IDLE, SGL, 1, OK, 0);
        @(posedge clk);
        #1 check_outs("post_rst", 5'b00001, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
